exec_alu_unit: RTL and testbench

- Registered execute-stage datapath for the 64-bit LEGv8 pipelined CPU.
- Combines three functions:
  - ALU-control decode from ALUOp plus instruction bits [31:21].
  - A 64-bit ALU with zero flag.
  - Two address adders: PC+4 and branch target PC+(imm<<2).
- All outputs are registered (1-cycle latency) so the block can replace the EX logic feeding the EX/MEM register.

---
 rtl/exec_alu_unit.sv | 98 +++++++++
 tb/tb_exec_alu_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/exec_alu_unit.sv
// Registered LEGv8 execute stage: ALU-control decode, 64-bit ALU with zero flag,
// and the PC+4 / branch-target adders, all presented one cycle after sampling.
module exec_alu_unit #(
   parameter int WIDTH   = 64,
   parameter int PC_STEP = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [1:0]       alu_op,
   input  logic [10:0]      opcode,
   input  logic             alu_src,
   input  logic [WIDTH-1:0] reg_data_1,
   input  logic [WIDTH-1:0] reg_data_2,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] pc,
   output logic             out_valid,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target
);

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;

   localparam logic [3:0] CTRL_AND  = 4'b0000;
   localparam logic [3:0] CTRL_ORR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD  = 4'b0010;
   localparam logic [3:0] CTRL_SUB  = 4'b0110;
   localparam logic [3:0] CTRL_PASS = 4'b0111;
   localparam logic [3:0] CTRL_NOR  = 4'b1100;

   localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

   logic [3:0]       ctrl_next;
   logic             illegal_next;
   logic [WIDTH-1:0] operand_b;
   logic [WIDTH-1:0] result_next;

   // Unknown R-type opcodes fall back to ADD so the datapath stays defined; illegal flags them.
   always_comb begin
      ctrl_next    = CTRL_ADD;
      illegal_next = 1'b0;
      if (alu_op == 2'b01) begin
         ctrl_next = CTRL_PASS;
      end else if (alu_op[1]) begin
         case (opcode)
            OPC_ADD: ctrl_next = CTRL_ADD;
            OPC_SUB: ctrl_next = CTRL_SUB;
            OPC_AND: ctrl_next = CTRL_AND;
            OPC_ORR: ctrl_next = CTRL_ORR;
            default: illegal_next = 1'b1;
         endcase
      end
   end

   assign operand_b = alu_src ? imm : reg_data_2;

   always_comb begin
      result_next = '0;
      case (ctrl_next)
         CTRL_AND:  result_next = reg_data_1 & operand_b;
         CTRL_ORR:  result_next = reg_data_1 | operand_b;
         CTRL_ADD:  result_next = reg_data_1 + operand_b;
         CTRL_SUB:  result_next = reg_data_1 + ~operand_b + STEP / STEP;
         CTRL_PASS: result_next = operand_b;
         CTRL_NOR:  result_next = ~(reg_data_1 | operand_b);
         default:   result_next = '0;
      endcase
   end

   // zero is cleared on reset rather than derived from the cleared result.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid     <= 1'b0;
         alu_ctrl      <= '0;
         result        <= '0;
         zero          <= 1'b0;
         illegal       <= 1'b0;
         pc_plus4      <= '0;
         branch_target <= '0;
      end else begin
         out_valid     <= in_valid;
         alu_ctrl      <= ctrl_next;
         result        <= result_next;
         zero          <= (result_next == '0);
         illegal       <= illegal_next;
         pc_plus4      <= pc + STEP;
         branch_target <= pc + {imm[WIDTH-3:0], 2'b00};
      end
   end

endmodule

// File: tb/tb_exec_alu_unit.sv
// Self-checking bench for exec_alu_unit: directed cases from the test plan plus
// randomized traffic, all compared against a behavioural model of the EX stage.
module tb_exec_alu_unit;

   localparam int WIDTH = 64;

   typedef struct {
      logic             valid;
      logic [3:0]       ctrl;
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             illegal;
      logic [WIDTH-1:0] pc4;
      logic [WIDTH-1:0] target;
   } expect_t;

   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [1:0]       alu_op;
   logic [10:0]      opcode;
   logic             alu_src;
   logic [WIDTH-1:0] reg_data_1;
   logic [WIDTH-1:0] reg_data_2;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] pc;
   logic             out_valid;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;
   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] branch_target;

   int check_count = 0;
   int error_count = 0;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;

   exec_alu_unit #(.WIDTH(WIDTH), .PC_STEP(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
      .opcode(opcode), .alu_src(alu_src), .reg_data_1(reg_data_1),
      .reg_data_2(reg_data_2), .imm(imm), .pc(pc), .out_valid(out_valid),
      .alu_ctrl(alu_ctrl), .result(result), .zero(zero), .illegal(illegal),
      .pc_plus4(pc_plus4), .branch_target(branch_target)
   );

   always #5 clock = ~clock;

   // Reference: instruction semantics in plain arithmetic, keyed by mnemonic.
   function automatic expect_t model(input logic v, input logic [1:0] op, input logic [10:0] opc,
                                     input logic src, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] r2, input logic [WIDTH-1:0] im,
                                     input logic [WIDTH-1:0] p);
      expect_t e;
      logic [WIDTH-1:0] b;
      string mnem;
      b = src ? im : r2;
      e.valid = v;
      e.illegal = 1'b0;
      if (op == 2'b00) mnem = "ADD";
      else if (op == 2'b01) mnem = "PASS";
      else if (opc == OPC_ADD) mnem = "ADD";
      else if (opc == OPC_SUB) mnem = "SUB";
      else if (opc == OPC_AND) mnem = "AND";
      else if (opc == OPC_ORR) mnem = "ORR";
      else begin
         mnem = "ADD";
         e.illegal = 1'b1;
      end
      case (mnem)
         "ADD": begin e.ctrl = 4'd2; e.result = a + b; end
         "SUB": begin e.ctrl = 4'd6; e.result = a - b; end
         "AND": begin e.ctrl = 4'd0; e.result = a & b; end
         "ORR": begin e.ctrl = 4'd1; e.result = a | b; end
         default: begin e.ctrl = 4'd7; e.result = b; end
      endcase
      e.zero = (e.result == 0);
      e.pc4 = p + 64'd4;
      e.target = p + im * 64'd4;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input expect_t e);
      checkOutput({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(e.valid));
      checkOutput({tag, ".alu_ctrl"}, WIDTH'(alu_ctrl), WIDTH'(e.ctrl));
      checkOutput({tag, ".result"}, result, e.result);
      checkOutput({tag, ".zero"}, WIDTH'(zero), WIDTH'(e.zero));
      checkOutput({tag, ".illegal"}, WIDTH'(illegal), WIDTH'(e.illegal));
      checkOutput({tag, ".pc_plus4"}, pc_plus4, e.pc4);
      checkOutput({tag, ".branch_target"}, branch_target, e.target);
   endtask

   // Drive one cycle of inputs at the falling edge, then check one step after the rising edge.
   task automatic applyStimulus(input string tag, input logic v, input logic [1:0] op,
                                input logic [10:0] opc, input logic src,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] r2,
                                input logic [WIDTH-1:0] im, input logic [WIDTH-1:0] p);
      expect_t e;
      @(negedge clock);
      reset = 1'b0;
      in_valid = v; alu_op = op; opcode = opc; alu_src = src;
      reg_data_1 = a; reg_data_2 = r2; imm = im; pc = p;
      e = model(v, op, opc, src, a, r2, im, p);
      @(posedge clock);
      #1;
      checkAll(tag, e);
   endtask

   task automatic applyReset(input string tag);
      expect_t z;
      z = '{valid: 1'b0, ctrl: 4'd0, result: '0, zero: 1'b0, illegal: 1'b0, pc4: '0, target: '0};
      @(negedge clock);
      reset = 1'b1;
      in_valid = 1'b1; alu_op = 2'b10; opcode = OPC_SUB; alu_src = 1'b0;
      reg_data_1 = 64'd9; reg_data_2 = 64'd9; imm = 64'h33; pc = 64'h1000;
      @(posedge clock);
      #1;
      checkAll(tag, z);
   endtask

   initial begin
      logic [1:0]       r_op;
      logic [10:0]      r_opc;
      logic [WIDTH-1:0] r_a, r_b;
      reset = 1'b1; in_valid = 1'b0; alu_op = '0; opcode = '0; alu_src = 1'b0;
      reg_data_1 = '0; reg_data_2 = '0; imm = '0; pc = '0;

      applyReset("reset0");
      applyReset("reset1");

      applyStimulus("load", 1, 2'b00, 11'd0, 1, 64'h100, 64'h0, 64'h18, 64'h40);
      applyStimulus("add", 1, 2'b10, OPC_ADD, 0, 64'd5, 64'd7, 64'd0, 64'h0);
      applyStimulus("sub", 1, 2'b10, OPC_SUB, 0, 64'd7, 64'd7, 64'd0, 64'h4);
      applyStimulus("and", 1, 2'b10, OPC_AND, 0, 64'hF0F0, 64'h0FF0, 64'd0, 64'h8);
      applyStimulus("orr", 1, 2'b11, OPC_ORR, 0, 64'hF0F0, 64'h0FF0, 64'd0, 64'hC);
      applyStimulus("cbz0", 1, 2'b01, 11'h123, 0, 64'd99, 64'd0, 64'd0, 64'h10);
      applyStimulus("cbz3", 1, 2'b01, 11'h000, 0, 64'd99, 64'd3, 64'd0, 64'h14);
      applyStimulus("cbzneg", 1, 2'b01, 11'h000, 0, 64'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'h20);
      applyStimulus("addwrap", 1, 2'b10, OPC_ADD, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h0);
      applyStimulus("pcwrap", 1, 2'b00, 11'd0, 1, 64'd1, 64'd0, 64'h4000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFC);
      applyStimulus("illegal", 1, 2'b10, 11'h7FF, 0, 64'd3, 64'd4, 64'd0, 64'h30);

      // Back-to-back valid ops, then a bubble.
      applyStimulus("pipe0", 1, 2'b10, OPC_SUB, 0, 64'd50, 64'd8, 64'd0, 64'h100);
      applyStimulus("pipe1", 1, 2'b10, OPC_AND, 1, 64'hFF00, 64'd0, 64'h0F0F, 64'h104);
      applyStimulus("pipe2", 1, 2'b00, 11'd0, 1, 64'd1, 64'd0, 64'd2, 64'h108);
      applyStimulus("pipe_idle", 0, 2'b10, OPC_ORR, 0, 64'd1, 64'd2, 64'd0, 64'h10C);

      applyStimulus("pre_rst", 1, 2'b10, OPC_ADD, 0, 64'd1, 64'd2, 64'd0, 64'h200);
      applyReset("mid_reset");
      applyStimulus("post_rst", 1, 2'b10, OPC_ORR, 0, 64'd1, 64'd2, 64'd3, 64'h204);

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 6))
            0: r_opc = OPC_ADD;
            1: r_opc = OPC_SUB;
            2: r_opc = OPC_AND;
            3: r_opc = OPC_ORR;
            default: r_opc = 11'($urandom);
         endcase
         r_op = 2'($urandom);
         r_a = {$urandom, $urandom};
         r_b = ($urandom_range(0, 5) == 0) ? r_a : {$urandom, $urandom};
         applyStimulus("rand", 1'($urandom), r_op, r_opc, 1'($urandom), r_a, r_b,
                       {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
